// File: rtl/motor_nn_pkg.sv
// Shared fixed-point and FSM definitions for the motor MPC network layers.
// ap_fixed<16,7>: 16-bit two's complement with 9 fractional bits.
package motor_nn_pkg;

  localparam int FIXED_W = 16;
  localparam int FIXED_I = 7;
  localparam int FRAC    = FIXED_W - FIXED_I;

  localparam logic [1:0] ST_IDLE_ENC = 2'd0;
  localparam logic [1:0] ST_MAC_ENC  = 2'd1;
  localparam logic [1:0] ST_DONE_ENC = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE_ENC,
    MAC  = ST_MAC_ENC,
    DONE = ST_DONE_ENC
  } state_t;

  // Full-precision product width plus growth for n_in products and the bias.
  function automatic int acc_width(input int n_in);
    return 2 * FIXED_W + $clog2(n_in + 1);
  endfunction

endpackage

// File: rtl/motor_mac_ap_fixed_16_7.sv
// Signed 16x16 multiply-accumulate with bias load; exposes the truncated next sum.
// One-cycle accumulate per enabled edge; no backpressure, driven by the layer FSM.
module motor_mac_ap_fixed_16_7
  import motor_nn_pkg::*;
#(
  parameter int ACC_W = 34
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic                      en,
  input  logic signed [FIXED_W-1:0] bias,
  input  logic signed [FIXED_W-1:0] a,
  input  logic signed [FIXED_W-1:0] b,
  output logic        [FIXED_W-1:0] res_nxt
);

  logic signed [2*FIXED_W-1:0] prod;
  logic signed [ACC_W-1:0]     acc;
  logic signed [ACC_W-1:0]     acc_nxt;

  assign prod    = a * b;
  assign acc_nxt = acc + ACC_W'(prod);
  // Drop 9 fractional bits (floor) and wrap to 16 bits.
  assign res_nxt = acc_nxt[FRAC +: FIXED_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (load) begin
      acc <= ACC_W'(bias) <<< FRAC;
    end else if (en) begin
      acc <= acc_nxt;
    end
  end

endmodule

// File: rtl/motor_dense_seq_ap_fixed_16_7_config6.sv
// Two-lane sequential dense layer, one MAC per lane over N_IN inputs; done N_IN edges after start.
// ap_start is only sampled in IDLE; results hold until the next completion or reset.
module motor_dense_seq_ap_fixed_16_7_config6
  import motor_nn_pkg::*;
#(
  parameter int                            N_IN   = 4,
  parameter logic [2*FIXED_W*N_IN-1:0]     W_FLAT = '0,
  parameter logic [2*FIXED_W-1:0]          B_FLAT = '0
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst,
  input  logic                      ap_start,
  output logic                      ap_done,
  output logic                      ap_idle,
  output logic                      ap_ready,
  input  logic [FIXED_W*N_IN-1:0]   data_in,
  output logic [FIXED_W-1:0]        ap_return_0,
  output logic [FIXED_W-1:0]        ap_return_1
);

  localparam int ACC_W = acc_width(N_IN);
  localparam int KW    = (N_IN > 1) ? $clog2(N_IN) : 1;

  state_t                     state, state_nxt;
  logic   [KW-1:0]            k;
  logic   [FIXED_W*N_IN-1:0]  x_reg;
  logic                       load, en, last;
  logic   [FIXED_W-1:0]       x_k, w0_k, w1_k;
  logic   [FIXED_W-1:0]       res0_nxt, res1_nxt;

  assign x_k  = x_reg[FIXED_W*k +: FIXED_W];
  assign w0_k = W_FLAT[FIXED_W*k +: FIXED_W];
  assign w1_k = W_FLAT[FIXED_W*(N_IN + k) +: FIXED_W];
  assign last = (k == KW'(N_IN - 1));

  always_ff @(posedge ap_clk) begin
    if (ap_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    en        = 1'b0;
    ap_idle   = 1'b0;
    ap_done   = 1'b0;
    ap_ready  = 1'b0;
    case (state)
      IDLE: begin
        ap_idle = 1'b1;
        if (ap_start) begin
          load      = 1'b1;
          state_nxt = MAC;
        end
      end
      MAC: begin
        en = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        ap_done   = 1'b1;
        ap_ready  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Results latch from the final accumulate so they are valid while ap_done is high.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      k           <= '0;
      x_reg       <= '0;
      ap_return_0 <= '0;
      ap_return_1 <= '0;
    end else if (load) begin
      x_reg <= data_in;
      k     <= '0;
    end else if (en) begin
      k <= k + KW'(1);
      if (last) begin
        ap_return_0 <= res0_nxt;
        ap_return_1 <= res1_nxt;
      end
    end
  end

  motor_mac_ap_fixed_16_7 #(.ACC_W(ACC_W)) u_mac0 (
    .clk     (ap_clk),
    .rst     (ap_rst),
    .load    (load),
    .en      (en),
    .bias    (B_FLAT[0 +: FIXED_W]),
    .a       (x_k),
    .b       (w0_k),
    .res_nxt (res0_nxt)
  );

  motor_mac_ap_fixed_16_7 #(.ACC_W(ACC_W)) u_mac1 (
    .clk     (ap_clk),
    .rst     (ap_rst),
    .load    (load),
    .en      (en),
    .bias    (B_FLAT[FIXED_W +: FIXED_W]),
    .a       (x_k),
    .b       (w1_k),
    .res_nxt (res1_nxt)
  );

endmodule
